// File: rtl/cache_mem_responder.sv
// Line-request responder: in-order request FIFO feeding a fixed-latency service FSM.
// Optional macro MEM_RESP_STATS_EN enables the numReads/numWrites completion counters.
module cache_mem_responder #(
  parameter int ADDRESS_SIZE = 32,
  parameter int LINESIZE     = 32,
  parameter int LATENCY      = 4,
  parameter int DEPTH        = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  input  logic                    req_rw,
  input  logic [ADDRESS_SIZE-1:0] req_address,
  output logic                    req_ready,
  output logic                    resp_valid,
  output logic                    resp_rw,
  output logic [ADDRESS_SIZE-1:0] resp_address,
  input  logic                    resp_ready,
  output logic [31:0]             numReads,
  output logic [31:0]             numWrites
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [PTR_W:0] COUNT_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [ADDRESS_SIZE-1:0] LINE_MASK = ~ADDRESS_SIZE'(LINESIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_t;

  state_t                    r_state;
  logic [PTR_W-1:0]          r_wr_ptr;
  logic [PTR_W-1:0]          r_rd_ptr;
  logic [PTR_W:0]            r_count;
  logic [CNT_W-1:0]          r_delay;
  logic                      r_resp_valid;
  logic                      r_resp_rw;
  logic [ADDRESS_SIZE-1:0]   r_resp_address;
  logic [ADDRESS_SIZE:0]     r_mem [DEPTH];

  logic                      w_full;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_resp_fire;
  logic [ADDRESS_SIZE:0]     w_head;

  // Readiness comes from the registered occupancy only; a pop never frees a slot same-cycle.
  assign w_full      = (r_count == COUNT_FULL);
  assign w_push      = req_valid & ~w_full;
  assign w_pop       = (r_state == S_IDLE) & (r_count != '0);
  assign w_resp_fire = r_resp_valid & resp_ready;
  assign w_head      = r_mem[r_rd_ptr];

  assign req_ready    = ~w_full;
  assign resp_valid   = r_resp_valid;
  assign resp_rw      = r_resp_rw;
  assign resp_address = r_resp_address;

  // Storage array has no reset so it maps onto RAM; occupancy is tracked by pointers/count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {req_rw, req_address};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_delay        <= '0;
      r_resp_valid   <= 1'b0;
      r_resp_rw      <= 1'b0;
      r_resp_address <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase

      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_resp_rw      <= w_head[ADDRESS_SIZE];
            r_resp_address <= w_head[ADDRESS_SIZE-1:0] & LINE_MASK;
            r_delay        <= CNT_W'(LATENCY);
            r_state        <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_delay == CNT_W'(1)) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
          end else begin
            r_delay <= r_delay - CNT_W'(1);
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            r_state      <= S_IDLE;
            r_resp_valid <= 1'b0;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_resp_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef MEM_RESP_STATS_EN
  logic [31:0] r_num_reads;
  logic [31:0] r_num_writes;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_num_reads  <= '0;
      r_num_writes <= '0;
    end else if (w_resp_fire) begin
      if (r_resp_rw) begin
        r_num_writes <= r_num_writes + 32'd1;
      end else begin
        r_num_reads <= r_num_reads + 32'd1;
      end
    end
  end

  assign numReads  = r_num_reads;
  assign numWrites = r_num_writes;
`else
  logic w_unused_fire;
  assign w_unused_fire = w_resp_fire;
  assign numReads      = '0;
  assign numWrites     = '0;
`endif

endmodule

// File: tb/tb_cache_mem_responder.sv
// Randomized and directed bench for cache_mem_responder against a queue-based timing model.
module tb_cache_mem_responder;
  localparam int AW  = 32;
  localparam int LS  = 32;
  localparam int LAT = 4;
  localparam int DEP = 4;
`ifdef MEM_RESP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam logic [AW-1:0] MASK = ~AW'(LS - 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_rw = 1'b0;
  logic [AW-1:0] req_address = '0;
  logic          resp_ready = 1'b0;
  logic          req_ready;
  logic          resp_valid;
  logic          resp_rw;
  logic [AW-1:0] resp_address;
  logic [31:0]   numReads;
  logic [31:0]   numWrites;

  cache_mem_responder #(
    .ADDRESS_SIZE(AW), .LINESIZE(LS), .LATENCY(LAT), .DEPTH(DEP)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_rw(req_rw), .req_address(req_address),
    .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rw(resp_rw), .resp_address(resp_address),
    .resp_ready(resp_ready),
    .numReads(numReads), .numWrites(numWrites)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          rw;
    logic [AW-1:0] addr;
  } item_t;

  // Model: waiting requests, one job in service counting down to its response.
  item_t       mq[$];
  bit          job_active;
  int          job_rem;
  item_t       job;
  bit          out_zero;
  int unsigned exp_reads, exp_writes;
  bit          model_on;
  int          pre_cnt;
  bit          pre_active, pre_valid;
  int          cyc;
  int          checks, failures;
  item_t       tx_log[$];
  item_t       rx_log[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      mq.delete();
      job_active = 0;
      job_rem    = 0;
      out_zero   = 1;
      exp_reads  = 0;
      exp_writes = 0;
      model_on   = 1;
    end else if (model_on) begin
      pre_cnt    = mq.size();
      pre_active = job_active;
      pre_valid  = job_active && (job_rem == 0);
      if (pre_valid && resp_ready) begin
        job_active = 0;
        if (job.rw) exp_writes++;
        else exp_reads++;
      end else if (pre_active && job_rem > 0) begin
        job_rem--;
      end
      if (!pre_active && pre_cnt > 0) begin
        job        = mq.pop_front();
        job_rem    = LAT;
        job_active = 1;
        out_zero   = 0;
      end
      if (req_valid && pre_cnt < DEP) mq.push_back(item_t'({req_rw, req_address}));
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("req_ready", req_ready, mq.size() < DEP);
      chk("resp_valid", resp_valid, job_active && job_rem == 0);
      if (job_active && job_rem == 0) begin
        chk("resp_rw", resp_rw, job.rw);
        chk("resp_address", resp_address, job.addr & MASK);
      end else if (out_zero) begin
        chk("resp_rw_rst", resp_rw, 0);
        chk("resp_address_rst", resp_address, 0);
      end
      chk("numReads", numReads, STATS ? exp_reads : 0);
      chk("numWrites", numWrites, STATS ? exp_writes : 0);
      if (reset && req_valid && req_ready) tx_log.push_back(item_t'({req_rw, req_address & MASK}));
      if (reset && resp_valid && resp_ready) rx_log.push_back(item_t'({resp_rw, resp_address}));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    req_valid  = 0;
    resp_ready = 1;
    n = 0;
    while ((job_active || mq.size() != 0) && n < 300) begin
      step();
      n++;
    end
    chk("drain_timeout", n < 300, 1);
  endtask

  task automatic compare_logs(input string tag);
    chk({tag, "_count"}, rx_log.size(), tx_log.size());
    for (int i = 0; i < tx_log.size() && i < rx_log.size(); i++) begin
      chk({tag, "_order"}, rx_log[i], tx_log[i]);
    end
  endtask

  task automatic wait_valid(output int at_cyc);
    at_cyc = -1;
    for (int i = 0; i < 60 && at_cyc < 0; i++) begin
      if (resp_valid) at_cyc = cyc;
      else step();
    end
    chk("valid_timeout", at_cyc >= 0, 1);
  endtask

  int k, first, acc;
  item_t exp_item;

  initial begin
    checks = 0;
    failures = 0;
    cyc = 0;
    model_on = 0;
    reset = 0;
    step();
    step();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rw", resp_rw, 0);
    chk("rst_resp_address", resp_address, 0);
    chk("rst_numReads", numReads, 0);
    chk("rst_numWrites", numWrites, 0);
    reset = 1;
    step();

    // Single read: first resp_valid after edge N+LAT+1, aligned address.
    resp_ready  = 1;
    req_valid   = 1;
    req_rw      = 0;
    req_address = 32'h0000_1234;
    k = cyc;
    step();
    req_valid = 0;
    wait_valid(first);
    chk("read_latency", first, k + 1 + LAT + 1);
    chk("read_addr_lit", resp_address, 32'h0000_1220);
    chk("read_rw_lit", resp_rw, 0);
    step();
    chk("model_reads_lit", exp_reads, 1);
    chk("numReads_lit", numReads, STATS ? 32'd1 : 32'd0);

    // Writeback at the top of the address space.
    drain();
    req_valid   = 1;
    req_rw      = 1;
    req_address = 32'hFFFF_FFFF;
    step();
    req_valid = 0;
    wait_valid(first);
    chk("wb_addr_lit", resp_address, 32'hFFFF_FFE0);
    chk("wb_rw_lit", resp_rw, 1);
    step();
    chk("numWrites_lit", numWrites, STATS ? 32'd1 : 32'd0);

    // Back-pressure: one request in service plus DEP queued, the rest stall.
    drain();
    tx_log.delete();
    rx_log.delete();
    resp_ready = 0;
    acc = 0;
    for (int i = 0; i < DEP + 2; i++) begin
      req_valid   = 1;
      req_rw      = 1'(i);
      req_address = $urandom;
      if (req_ready) acc++;
      step();
    end
    req_valid = 0;
    chk("bp_accepted_lit", acc, DEP + 1);
    chk("bp_ready_low", req_ready, 0);
    repeat (8) step();
    chk("bp_still_low", req_ready, 0);
    drain();
    compare_logs("bp");

    // Reset while BUSY with two requests queued.
    resp_ready = 0;
    for (int i = 0; i < 3; i++) begin
      req_valid   = 1;
      req_rw      = 0;
      req_address = $urandom;
      step();
    end
    req_valid = 0;
    chk("pre_rst_queue_lit", mq.size(), 2);
    chk("pre_rst_busy", resp_valid, 0);
    reset = 0;
    step();
    chk("post_rst_valid", resp_valid, 0);
    chk("post_rst_ready", req_ready, 1);
    chk("post_rst_reads", numReads, 0);
    chk("post_rst_writes", numWrites, 0);
    reset = 1;
    tx_log.delete();
    rx_log.delete();
    resp_ready = 1;
    repeat (20) step();
    chk("no_stale_resp", rx_log.size(), 0);

    // Randomized traffic with random response back-pressure.
    tx_log.delete();
    rx_log.delete();
    for (int i = 0; i < 400; i++) begin
      req_valid   = ($urandom_range(0, 2) == 0);
      req_rw      = 1'($urandom);
      req_address = $urandom;
      resp_ready  = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();
    chk("rand_enough", tx_log.size() >= 10, 1);
    compare_logs("rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
